pingpong_transpose: RTL

//   Ping-pong 8x8 transpose buffer between the 1-D row DCT and the 1-D column DCT.

---
 rtl/pingpong_transpose.sv | 81 ++++++++
 1 files changed

// File: rtl/pingpong_transpose.sv
// pingpong_transpose: two-bank 8x8 transpose buffer, rows in, columns out, with valid/ready on both sides
module pingpong_transpose #(
  parameter int W = 12,
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] in_row,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*W-1:0] out_col,
  output logic           out_last
);
  localparam int CW = $clog2(N);
  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} state_t;
  state_t         st_q [2];
  state_t         st_d [2];
  logic           wb_q, wb_d, rb_q, rb_d;
  logic [CW-1:0]  wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic [N*W-1:0] bank_q [2][N];
  logic           acc, take;
  assign in_ready  = (st_q[wb_q] == EMPTY) || (st_q[wb_q] == FILLING);
  assign out_valid = (st_q[rb_q] == FULL) || (st_q[rb_q] == DRAINING);
  assign out_last  = out_valid && (rd_cnt_q == CW'(N - 1));
  assign acc       = in_valid && in_ready;
  assign take      = out_valid && out_ready;
  // Bank state and pointers advance; accept and take always hit different banks
  always_comb begin
    st_d     = st_q;
    wb_d     = wb_q;
    rb_d     = rb_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    if (acc) begin
      st_d[wb_q] = FILLING;
      wr_cnt_d   = wr_cnt_q + CW'(1);
      if (wr_cnt_q == CW'(N - 1)) begin
        st_d[wb_q] = FULL;
        wr_cnt_d   = '0;
        wb_d       = ~wb_q;
      end
    end
    if (take) begin
      st_d[rb_q] = DRAINING;
      rd_cnt_d   = rd_cnt_q + CW'(1);
      if (rd_cnt_q == CW'(N - 1)) begin
        st_d[rb_q] = EMPTY;
        rd_cnt_d   = '0;
        rb_d       = ~rb_q;
      end
    end
  end
  // Control registers; a reset discards any partial block
  always_ff @(posedge clk) begin
    if (!rstn) begin
      st_q     <= '{EMPTY, EMPTY};
      wb_q     <= 1'b0;
      rb_q     <= 1'b0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      st_q     <= st_d;
      wb_q     <= wb_d;
      rb_q     <= rb_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end
  // Coefficient storage is deliberately left unreset
  always_ff @(posedge clk) begin
    if (acc) bank_q[wb_q][wr_cnt_q] <= in_row;
  end
  // Column gather: element r comes from row r of the draining bank, forced to zero when idle
  always_comb begin
    out_col = '0;
    for (int r = 0; r < N; r++)
      out_col[r*W +: W] = out_valid ? bank_q[rb_q][r][rd_cnt_q*W +: W] : '0;
  end
endmodule
